hanoi_mover: RTL
================

# hanoi_mover

Move generator that produces the optimal Tower of Hanoi move sequence for an N-disk tower and drives it, one move at a time, into the Hanoi game block. The game block consumes `fr`/`to` peg pairs. This block is the initiator side of that move interface: it computes each move with the iterative closed-form rule, presents it under a valid/ready handshake, and keeps a mirror of the three peg bitmaps for cross-checking against the game's `O1`/`O2`/`O3`.

## Interface
- `N`, default 4: number of disks; legal range 1..8.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to solve; sampled only in IDLE.
- `mv_valid`  out  1  a move is presented on `fr`/`to`/`disk`.
- `mv_ready`  in  1  the consumer accepts the move when `mv_valid && mv_ready`.
- `fr`  out  2  source peg (0, 1 or 2).
- `to`  out  2  destination peg (0, 1 or 2).
- `disk`  out  3  index of the disk being moved; 0 is the smallest.
- `move_cnt`  out  N  number of moves accepted in the current run.
- `busy`  out  1  high in CALC and SEND.
- `done`  out  1  one-cycle pulse after the last move is accepted.
- `O1`, `O2`, `O3`  out  N each  mirror peg bitmaps; bit i = disk i present.

## Operation
- States:
  - IDLE → CALC on `start`.
  - CALC → SEND, always, after 1 cycle.
  - SEND → CALC on accept when k < 2^N−1.
  - SEND → DONE on accept when k = 2^N−1.
  - DONE → IDLE, always, after 1 cycle.
- Move counter k (N+1 bits internally):
  - set to 1 on `start`;
  - incremented on each accept.
- In CALC, register the move for the current k:
  - `fr` = (k & (k−1)) mod 3;
  - `to` = ((k | (k−1)) + 1) mod 3;
  - `disk` = number of trailing zeros of k.
- Compute mod 3 in full width (N+1 bits); never truncate before the reduction.
- Final tower position:
  - N odd: the tower ends on peg 2 (`O3`);
  - N even: the tower ends on peg 1 (`O2`).
- Mirror pegs:
  - on `start`, load `O1` = all ones and `O2` = `O3` = 0;
  - on each accept, clear bit `disk` in peg `fr` and set it in peg `to`.
- `move_cnt` is cleared on `start` and incremented on each accept. After a full run it reads 2^N−1.
- `start` in CALC, SEND or DONE is ignored; a run cannot be restarted mid-sequence except by `rst`.
- Consistency rule: in SEND, bit `disk` of the `fr` mirror peg is 1, and `disk` is the lowest set bit of that peg. The bench checks this rule.

## Timing
- Reset values (asynchronous, while `rst` = 0):
  - state IDLE, k = 0;
  - `mv_valid` = 0, `busy` = 0, `done` = 0;
  - `fr` = 0, `to` = 0, `disk` = 0, `move_cnt` = 0;
  - `O1` = all ones, `O2` = 0, `O3` = 0.
- Release of `rst` takes effect at the first rising edge after deassertion.
- `start` high at edge t: `busy` = 1 from t+1; `mv_valid` = 1 from t+2 (CALC occupies t+1).
- Handshake rules:
  - `mv_valid` stays high until accepted;
  - `fr`/`to`/`disk` are stable while `mv_valid` is high and unaccepted;
  - `mv_valid` never depends combinationally on `mv_ready`.
- Accept at edge t:
  - `mv_valid` = 0 at t+1 (CALC);
  - the next move is valid at t+2;
  - peak throughput is one move per 2 cycles.
- `mv_ready` held high for a full N=4 run: the first move is valid at start+2 and the last is accepted at start+31.
- Last accept at edge t: `done` = 1 and `busy` = 0 during cycle t+1; IDLE from t+2. `start` at t+2 begins a new run.
- `rst` mid-run: all outputs return to their reset values immediately; no partial move is considered accepted.

## Test plan
- Reset: hold `rst` = 0 for 3 cycles → `O1` = 4'hF, `O2` = `O3` = 0, `mv_valid` = 0, `done` = 0, `move_cnt` = 0.
- Full run, N=4, `mv_ready` = 1 → exactly 15 moves:
  - first 8 (fr→to): 0→2, 0→1, 2→1, 0→2, 1→0, 1→2, 0→2, 0→1;
  - `disk` sequence starts 0,1,0,2,0,1,0,3;
  - `done` pulses once; final `O2` = 4'hF; `move_cnt` = 15.
- Backpressure: `mv_ready` = 0 for 5 cycles on move 3 → `fr`=2, `to`=1, `disk`=0 held stable with `mv_valid` = 1; sequence resumes unchanged after `mv_ready` rises.
- Odd N: N=3 run → 7 moves, final `O3` = 3'b111; the mirror consistency rule holds on every SEND cycle.
- Ignored start: pulse `start` during move 5 → no restart; 15 moves total; `move_cnt` continuous.
- Mid-run reset: assert `rst` in SEND of move 6 → outputs at reset values within the same cycle. A fresh `start` then regenerates the sequence from 0→2.

Source files
------------

// File: rtl/hanoi_mover.sv
// hanoi_mover: produces the optimal Tower of Hanoi move sequence for an
// N-disk tower. Each move is presented on fr/to/disk under a valid/ready
// handshake. The block keeps mirror peg bitmaps so the game's pegs can be
// cross-checked against them.
module hanoi_mover #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic         mv_valid,
  input  logic         mv_ready,
  output logic [1:0]   fr,
  output logic [1:0]   to,
  output logic [2:0]   disk,
  output logic [N-1:0] move_cnt,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] O1,
  output logic [N-1:0] O2,
  output logic [N-1:0] O3
);

  // k runs to 2^N, so it needs one bit more than the disk count.
  localparam int            KW     = N + 1;
  localparam logic [KW-1:0] K_LAST = {1'b0, {N{1'b1}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_SEND, S_DONE} state_t;

  state_t        state, state_nxt;
  logic [KW-1:0] k;
  logic [N-1:0]  peg     [3];
  logic [N-1:0]  peg_nxt [3];
  logic [N-1:0]  disk_mask;
  logic          go;
  logic          accept;

  // The reduction runs on the full k width; truncating first would give wrong pegs.
  function automatic logic [1:0] mod3(input logic [KW-1:0] v);
    logic [KW-1:0] r;
    r = v % KW'(3);
    return r[1:0];
  endfunction

  // The disk that moves at step k is the number of trailing zeros of k.
  function automatic logic [2:0] ctz(input logic [KW-1:0] v);
    logic [2:0] n;
    n = '0;
    for (int i = KW - 1; i >= 0; i--) begin
      if (v[i]) n = 3'(i);
    end
    return n;
  endfunction

  assign go        = (state == S_IDLE) && start;
  assign accept    = (state == S_SEND) && mv_ready;
  assign mv_valid  = (state == S_SEND);
  assign busy      = (state == S_CALC) || (state == S_SEND);
  assign done      = (state == S_DONE);
  assign disk_mask = N'(1) << disk;
  assign O1        = peg[0];
  assign O2        = peg[1];
  assign O3        = peg[2];

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: clocked state uses non-blocking (<=) so all registers update together at the edge.
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic; start is looked at only in IDLE.
  always_comb begin
    // NOTE: the default assignment first means no path leaves state_nxt unassigned, so no latch.
    state_nxt = state;
    unique case (state)
      S_IDLE: if (start) state_nxt = S_CALC;
      S_CALC: state_nxt = S_SEND;
      S_SEND: if (mv_ready) state_nxt = (k == K_LAST) ? S_DONE : S_CALC;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Mirror pegs after the accepted move: take the disk off fr and put it on to.
  always_comb begin
    for (int p = 0; p < 3; p++) begin
      peg_nxt[p] = peg[p];
      if (accept && (fr == 2'(p))) peg_nxt[p] = peg_nxt[p] & ~disk_mask;
      if (accept && (to == 2'(p))) peg_nxt[p] = peg_nxt[p] | disk_mask;
    end
  end

  // Datapath: move counter, registered move, and mirror pegs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k        <= '0;
      fr       <= '0;
      to       <= '0;
      disk     <= '0;
      move_cnt <= '0;
      // NOTE: the three mirror pegs are plain flops, not RAM, so each one gets an explicit reset value.
      peg[0]   <= '1;
      peg[1]   <= '0;
      peg[2]   <= '0;
    end else begin
      if (go) begin
        k        <= KW'(1);
        move_cnt <= '0;
        peg[0]   <= '1;
        peg[1]   <= '0;
        peg[2]   <= '0;
      end else if (accept) begin
        k        <= k + KW'(1);
        move_cnt <= move_cnt + N'(1);
        peg[0]   <= peg_nxt[0];
        peg[1]   <= peg_nxt[1];
        peg[2]   <= peg_nxt[2];
      end
      if (state == S_CALC) begin
        fr   <= mod3(k & (k - KW'(1)));
        to   <= mod3((k | (k - KW'(1))) + KW'(1));
        disk <= ctz(k);
      end
    end
  end

endmodule
